// File: rtl/riscv_ctrl_pkg.sv
// Control constants shared by the IITB-RISC control path: sequencer state
// encoding, ALU operation codes and default datapath sizes.
package riscv_ctrl_pkg;

  localparam int NUM_REGS_DEF  = 8;
  localparam int REG_IDX_W_DEF = 3;
  localparam int ADDR_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] ALUOP_ADDTYPE = 2'b00;
  localparam logic [1:0] ALUOP_NAND    = 2'b01;
  localparam logic [1:0] ALUOP_ADD     = 2'b10;
  localparam logic [1:0] ALUOP_SUB     = 2'b11;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit of a mask,
// plus a valid flag that is low when the mask is empty.
module lowest_set_bit_enc #(
  parameter int NUM_REGS  = 8,
  parameter int REG_IDX_W = 3
) (
  input  logic [NUM_REGS-1:0]  mask,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 vld
);

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = REG_IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a register mask from R0 upward, issuing one memory
// transfer per set bit and stepping the address through the shared ALU.
module lm_sm_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [NUM_REGS-1:0]  reg_list,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 mem_ready,
  input  logic [ADDR_W-1:0]    alu_result,
  output logic                 busy,
  output logic                 done,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 rf_wr,
  output logic [1:0]           aluop,
  output logic [ADDR_W-1:0]    alu_a,
  output logic [ADDR_W-1:0]    alu_b
);

  seq_state_e           state;
  logic [NUM_REGS-1:0]  pending;
  logic                 store;
  logic [NUM_REGS-1:0]  pending_clr;
  logic [NUM_REGS-1:0]  next_mask;
  logic [REG_IDX_W-1:0] next_idx;
  logic                 next_vld;

  // reg_idx always names the lowest pending bit while in XFER, so clearing it
  // retires the current transfer; one encoder serves both start and advance.
  assign pending_clr = pending & ~(NUM_REGS'(1) << reg_idx);
  assign next_mask   = (state == ST_IDLE) ? reg_list : pending_clr;

  lowest_set_bit_enc #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_enc (
    .mask (next_mask),
    .idx  (next_idx),
    .vld  (next_vld)
  );

  assign rf_wr = (state == ST_XFER) && mem_ready && !store;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pending  <= '0;
      store    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      reg_idx  <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      aluop    <= ALUOP_ADDTYPE;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (next_vld) begin
              state    <= ST_XFER;
              pending  <= reg_list;
              store    <= is_store;
              reg_idx  <= next_idx;
              mem_addr <= base_addr;
              mem_rd   <= !is_store;
              mem_wr   <= is_store;
              aluop    <= ALUOP_ADD;
              alu_a    <= base_addr;
              alu_b    <= ADDR_W'(1);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (mem_ready) begin
            pending  <= pending_clr;
            mem_addr <= alu_result;
            alu_a    <= alu_result;
            reg_idx  <= next_idx;
            if (!next_vld) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              reg_idx  <= '0;
              mem_addr <= '0;
              mem_rd   <= 1'b0;
              mem_wr   <= 1'b0;
              aluop    <= ALUOP_ADDTYPE;
              alu_a    <= '0;
              alu_b    <= '0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          reg_idx  <= '0;
          mem_addr <= '0;
          mem_rd   <= 1'b0;
          mem_wr   <= 1'b0;
          aluop    <= ALUOP_ADDTYPE;
          alu_a    <= '0;
          alu_b    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed and randomized LM/SM sequences checked
// cycle by cycle against a list-of-transfers reference model.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        mem_ready;
  logic [15:0] alu_result;
  logic        busy, done, mem_rd, mem_wr, rf_wr;
  logic [2:0]  reg_idx;
  logic [15:0] mem_addr, alu_a, alu_b;
  logic [1:0]  aluop;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] addr;
  } xfer_t;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: always adds its operands.
  assign alu_result = alu_a + alu_b;

  lm_sm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .mem_ready  (mem_ready),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .reg_idx    (reg_idx),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .rf_wr      (rf_wr),
    .aluop      (aluop),
    .alu_a      (alu_a),
    .alu_b      (alu_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic eb, input logic ed,
                            input logic [2:0] ei, input logic [15:0] ea,
                            input logic er, input logic ew, input logic ef,
                            input logic [1:0] eop, input logic [15:0] eaa,
                            input logic [15:0] eab);
    chk({tag, ".busy"},     32'(busy),     32'(eb));
    chk({tag, ".done"},     32'(done),     32'(ed));
    chk({tag, ".reg_idx"},  32'(reg_idx),  32'(ei));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
    chk({tag, ".mem_rd"},   32'(mem_rd),   32'(er));
    chk({tag, ".mem_wr"},   32'(mem_wr),   32'(ew));
    chk({tag, ".rf_wr"},    32'(rf_wr),    32'(ef));
    chk({tag, ".aluop"},    32'(aluop),    32'(eop));
    chk({tag, ".alu_a"},    32'(alu_a),    32'(eaa));
    chk({tag, ".alu_b"},    32'(alu_b),    32'(eab));
  endtask

  task automatic expect_idle(input string tag);
    expect_out(tag, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
  endtask

  // One transfer per set bit, lowest register first, consecutive addresses.
  function automatic void build_model(input logic [7:0] list, input logic [15:0] base,
                                      ref xfer_t q[$]);
    logic [15:0] a;
    a = base;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        q.push_back('{idx: 3'(i), addr: a});
        a = a + 16'd1;
      end
    end
  endfunction

  // Called at a negedge; returns at a negedge with the sequence back in IDLE.
  task automatic run_seq(input string tag, input logic st, input logic [7:0] list,
                         input logic [15:0] base, input int first_stall,
                         input bit rand_stall, input bit poke);
    xfer_t q[$];
    int    stalls;
    build_model(list, base, q);
    start     = 1'b1;
    is_store  = st;
    reg_list  = list;
    base_addr = base;
    mem_ready = 1'($urandom);
    @(negedge clk);
    start     = 1'b0;
    is_store  = 1'($urandom);
    reg_list  = 8'($urandom);
    base_addr = 16'($urandom);
    foreach (q[k]) begin
      stalls = (k == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        mem_ready = (s == stalls);
        if (poke && k == 1 && s == 0) begin
          start     = 1'b1;
          reg_list  = ~list;
          is_store  = ~st;
          base_addr = base + 16'h4000;
        end else begin
          start = 1'b0;
        end
        #1;
        expect_out({tag, ".xfer"}, 1'b1, 1'b0, q[k].idx, q[k].addr, !st, st,
                   mem_ready && !st, 2'b10, q[k].addr, 16'd1);
        @(negedge clk);
      end
    end
    start     = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    expect_out({tag, ".done"}, 1'b1, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    expect_idle({tag, ".after"});
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    reg_list  = 8'h00;
    base_addr = 16'h0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    expect_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    run_seq("empty",  1'b0, 8'b0000_0000, 16'h1234, 0, 1'b0, 1'b0);
    run_seq("lm3",    1'b0, 8'b1000_0101, 16'h0100, 0, 1'b0, 1'b0);
    run_seq("sm_wrap", 1'b1, 8'hFF,       16'hFFFE, 0, 1'b0, 1'b0);
    run_seq("stall",  1'b0, 8'b0000_0011, 16'h0040, 3, 1'b0, 1'b0);

    // Abandon an SM sequence with reset during its second transfer.
    mem_ready = 1'b1;
    start     = 1'b1;
    is_store  = 1'b1;
    reg_list  = 8'b0000_1111;
    base_addr = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    #1;
    expect_out("abort.x0", 1'b1, 1'b0, 3'd0, 16'h0200, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0200, 16'd1);
    @(negedge clk);
    #1;
    expect_out("abort.x1", 1'b1, 1'b0, 3'd1, 16'h0201, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0201, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_idle("abort.rst");
    @(negedge clk);
    #1;
    expect_idle("abort.nodone");
    @(negedge clk);
    run_seq("after_abort", 1'b1, 8'b0001_0000, 16'h0300, 0, 1'b0, 1'b0);

    run_seq("poke", 1'b1, 8'b0110_1001, 16'h0800, 0, 1'b0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] rl;
      rl = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_seq("rand", 1'($urandom), rl, 16'($urandom), int'($urandom_range(0, 2)),
              1'b1, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Multi-cycle sequencer for IITB-RISC LM/SM (load/store multiple) instructions.
- Walks an 8-bit register list from R0 upward, issuing one memory transfer per set bit.
- Advances the memory address through the shared ALU (aluop = add, operand B = 1) instead of a private incrementer.
- Sits between the main control FSM, which starts it and waits for done, and the register file, memory port and alu_control input.

Parameters:
- NUM_REGS, 8, number of architectural registers and width of reg_list.
- REG_IDX_W, 3, width of the register index.
- ADDR_W, 16, address and data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from the main FSM; sampled only in IDLE.
- is_store  input  1  1 = SM (memory write), 0 = LM (memory read); latched at start.
- reg_list  input  NUM_REGS  register mask from the instruction immediate; latched at start.
- base_addr  input  ADDR_W  starting address (contents of RA); latched at start.
- mem_ready  input  1  memory completes the current transfer this cycle.
- alu_result  input  ADDR_W  ALU output, always alu_a + alu_b.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- reg_idx  output  REG_IDX_W  register being transferred: RF read port for SM, write port for LM.
- mem_addr  output  ADDR_W  current transfer address.
- mem_rd  output  1  read strobe, LM only.
- mem_wr  output  1  write strobe, SM only.
- rf_wr  output  1  register-file write enable; LM only, high in the cycle mem_ready completes a read.
- aluop  output  2  drives alu_control.aluop.
- alu_a  output  ADDR_W  ALU operand A.
- alu_b  output  ADDR_W  ALU operand B.

Behaviour:
- States: IDLE, XFER, DONE; encoding lives in the package.
- Reset (synchronous, active-high):
  - state = IDLE; pending mask, address register and is_store latch cleared.
  - All outputs 0, aluop = 2'b00.
  - Reset overrides every state: a mid-transfer reset abandons the sequence with no done pulse and no further strobes.
- IDLE:
  - busy = 0; start with is_store/reg_list/base_addr latched on that edge.
  - start && reg_list != 0: pending <= reg_list, addr <= base_addr, store <= is_store, go to XFER.
  - start && reg_list == 0: go straight to DONE; no memory or RF activity.
  - start is ignored in every state other than IDLE.
- XFER:
  - reg_idx = index of the lowest set bit in pending.
  - mem_addr = addr.
  - mem_rd = ~store, mem_wr = store.
  - aluop = 2'b10 (addition), alu_a = addr, alu_b = 1.
  - On mem_ready:
    - clear bit reg_idx in pending;
    - addr <= alu_result;
    - rf_wr = ~store, combinational, same cycle;
    - if the pending mask after clearing is 0, go to DONE, else stay in XFER.
  - mem_ready low: hold all outputs and state; this is an unbounded stall.
- DONE: done = 1, busy = 1 for exactly one cycle, then IDLE.
- Outputs outside XFER: mem_rd, mem_wr, rf_wr = 0; aluop = 2'b00; alu_a, alu_b, mem_addr, reg_idx = 0.
- Latency, with mem_ready tied high and N set bits, start at edge 0:
  - XFER occupies cycles 1..N, done in cycle N+1, IDLE in cycle N+2.
  - Empty list: done in cycle 1.
- Address arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 wraps to 16'h0000 with no error.
- Strobes are mutually exclusive: mem_rd and mem_wr are never both high.

Decomposition:
- Shared package (riscv_ctrl_pkg):
  - state encoding constants for IDLE, XFER, DONE;
  - ALUOP_ADDTYPE = 2'b00, ALUOP_NAND = 2'b01, ALUOP_ADD = 2'b10, ALUOP_SUB = 2'b11;
  - NUM_REGS, ADDR_W defaults.
- One sub-module, lowest_set_bit_enc:
  - NUM_REGS-bit mask in; REG_IDX_W index and valid out;
  - purely combinational, lowest index wins.

Test Plan:
1. Reset, then start with reg_list = 8'b0000_0000 -> busy=1 and done=1 in cycle 1, no mem_rd/mem_wr/rf_wr ever, IDLE in cycle 2.
2. LM, reg_list = 8'b1000_0101, base_addr = 16'h0100, mem_ready=1 -> reg_idx/mem_addr sequence (0,0100), (2,0101), (7,0102); rf_wr high in each of cycles 1-3; aluop=2'b10 in each; done in cycle 4.
3. SM, reg_list = 8'hFF, base_addr = 16'hFFFE, mem_ready=1 -> addresses FFFE, FFFF, 0000..0005; mem_wr high for 8 cycles, rf_wr never; done in cycle 9.
4. LM, reg_list = 8'b0000_0011, mem_ready low for 3 cycles on the first transfer -> reg_idx=0 and mem_addr held throughout the stall, rf_wr only on the ready cycle; done 2 cycles after the second completion starts (total done at cycle 6).
5. SM of 4 registers, reset asserted in the 2nd XFER cycle -> next cycle state IDLE, all outputs 0, no done pulse; a new start with reg_list = 8'b0001_0000 then completes normally with reg_idx=4.
6. start pulsed again while busy in XFER with a different reg_list -> ignored: original sequence and address unaffected, exactly one done.
